// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock for a stable
// window, then releases the system reset; retries on timeout, re-resets on lock loss.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {RST_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_pipe;
  logic          locked_s;

  // pll_locked is asynchronous to refclk; only the second flop is trusted
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], pll_locked};
  end

  assign locked_s = sync_pipe[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= RST_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      cnt       <= cnt + CW'(1);
      lock_lost <= 1'b0;
      unique case (state)
        RST_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= RST_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != 4'hF) retry_cnt <= retry_cnt + 4'd1;
          end
        end
        STABLE: begin
          // a dropout restarts qualification but is not counted as a retry
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state <= RST_PLL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random
// lock patterns, all checked against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;
  localparam int PRC = 4, LTO = 32, LST = 8;

  logic       refclk = 1'b0, rst = 1'b0, pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost;
  logic [3:0] retry_cnt;
  logic [7:0] dut_vec;
  int         n_checks = 0, n_fail = 0;

  pll_lock_sequencer #(.PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .LOCK_STABLE(LST)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;
  assign dut_vec = {pll_rst, sys_rst, ready, lock_lost, retry_cnt};

  // Reference model: which phase we are in and how many edges have elapsed in it;
  // lock is seen two edges late through a history of sampled values.
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STB = 2, PH_RUN = 3;
  int         m_phase, m_age;
  logic [3:0] m_retry;
  logic       m_lost, h1, h2;

  always @(posedge refclk or posedge rst) begin : model
    int np, na;
    logic [3:0] nr;
    logic nl;
    if (rst) begin
      m_phase <= PH_RST; m_age <= 0; m_retry <= 4'd0; m_lost <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
    end else begin
      np = m_phase; na = m_age + 1; nr = m_retry; nl = 1'b0;
      case (m_phase)
        PH_RST:  if (na == PRC) np = PH_WAIT;
        PH_WAIT: if (h2) np = PH_STB;
                 else if (na == LTO) begin np = PH_RST; nr = (m_retry == 4'd15) ? 4'd15 : m_retry + 4'd1; end
        PH_STB:  if (!h2) np = PH_WAIT; else if (na == LST) np = PH_RUN;
        default: if (!h2) begin np = PH_RST; nl = 1'b1; end
      endcase
      if (np != m_phase) na = 0;
      m_phase <= np; m_age <= na; m_retry <= nr; m_lost <= nl;
      h2 <= h1; h1 <= pll_locked;
    end
  end

  function automatic logic [7:0] exp_vec();
    return {m_phase == PH_RST, m_phase != PH_RUN, m_phase == PH_RUN, m_lost, m_retry};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1; pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    n_checks++;
    if (dut_vec !== 8'b1100_0000) begin n_fail++; $display("FAIL reset_values got %b want %b", dut_vec, 8'b1100_0000); end
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_model got %b want %b", dut_vec, exp_vec()); end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    logic ep; logic [3:0] er;
    for (int i = 1; i <= PRC + LTO; i++) begin
      @(negedge refclk);
      ep = (i < PRC) || (i == PRC + LTO);
      er = (i == PRC + LTO) ? 4'd1 : 4'd0;
      n_checks++;
      if ({pll_rst, retry_cnt} !== {ep, er}) begin
        n_fail++; $display("FAIL timeout edge %0d got pll_rst=%b retry=%0d want pll_rst=%b retry=%0d", i, pll_rst, retry_cnt, ep, er);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL timeout_model edge %0d got %b want %b", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_lock(input logic [3:0] er);
    int w;
    w = PRC + $urandom_range(0, 10);
    repeat (w) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lock_wait_model got %b want %b", dut_vec, exp_vec()); end
    end
    pll_locked = 1'b1;
    for (int j = 0; j <= LST + 3; j++) begin
      @(negedge refclk);
      n_checks++;
      if ({sys_rst, ready, retry_cnt} !== {j < LST + 2, j >= LST + 2, er}) begin
        n_fail++; $display("FAIL lock_latency k+%0d got sys_rst=%b ready=%b retry=%0d want sys_rst=%b ready=%b retry=%0d",
                           j, sys_rst, ready, retry_cnt, j < LST + 2, j >= LST + 2, er);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lock_model k+%0d got %b want %b", j, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_lock_loss(input logic [3:0] er);
    logic [7:0] want;
    pll_locked = 1'b0;
    for (int j = 0; j <= PRC + 2; j++) begin
      @(negedge refclk);
      want = {(j >= 2) && (j < PRC + 2), j >= 2, j < 2, j == 2, er};
      n_checks++;
      if (dut_vec !== want) begin n_fail++; $display("FAIL lock_loss k+%0d got %b want %b", j, dut_vec, want); end
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lock_loss_model k+%0d got %b want %b", j, dut_vec, exp_vec()); end
    end
  endtask

  // Lock rises at edge k; a one-cycle dropout is sampled at edge k+d+1.
  task automatic test_glitch(input int d, input logic [3:0] er);
    logic [7:0] want;
    pll_locked = 1'b1;
    for (int j = 0; j <= d + 13; j++) begin
      @(negedge refclk);
      want = {1'b0, j < d + 12, j >= d + 12, 1'b0, er};
      n_checks++;
      if (dut_vec !== want) begin n_fail++; $display("FAIL glitch d=%0d k+%0d got %b want %b", d, j, dut_vec, want); end
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL glitch_model d=%0d k+%0d got %b want %b", d, j, dut_vec, exp_vec()); end
      if (j == d) pll_locked = 1'b0;
      if (j == d + 1) pll_locked = 1'b1;
    end
  endtask

  task automatic test_saturate(input int er0);
    int rises, e;
    logic prev, wrapped;
    logic [3:0] prev_r;
    rises = 0; prev = 1'b0; wrapped = 1'b0; prev_r = 4'(er0);
    pll_locked = 1'b0;
    for (int j = 0; j <= 2 + (PRC + LTO) * 20; j++) begin
      @(negedge refclk);
      e = er0 + ((j >= 2) ? (j - 2) / (PRC + LTO) : 0);
      if (e > 15) e = 15;
      n_checks++;
      if (retry_cnt !== 4'(e)) begin n_fail++; $display("FAIL saturate_retry k+%0d got %0d want %0d", j, retry_cnt, e); end
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL saturate_model k+%0d got %b want %b", j, dut_vec, exp_vec()); end
      if (pll_rst && !prev) rises++;
      if (retry_cnt < prev_r) wrapped = 1'b1;
      prev = pll_rst; prev_r = retry_cnt;
    end
    n_checks++;
    if (retry_cnt !== 4'd15 || wrapped) begin n_fail++; $display("FAIL saturate_final got retry=%0d wrapped=%b want retry=15 wrapped=0", retry_cnt, wrapped); end
    n_checks++;
    if (rises != 21) begin n_fail++; $display("FAIL saturate_pulses got %0d want 21", rises); end
  endtask

  task automatic test_rst_async();
    rst = 1'b1; pll_locked = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
    repeat (3 * (PRC + LTO)) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rst_async_model got %b want %b", dut_vec, exp_vec()); end
    end
    pll_locked = 1'b1;
    repeat (16) @(negedge refclk);
    n_checks++;
    if ({ready, retry_cnt} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL rst_async_pre got ready=%b retry=%0d want ready=1 retry=3", ready, retry_cnt); end
    @(posedge refclk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 8'b1100_0000) begin n_fail++; $display("FAIL rst_async_immediate got %b want %b", dut_vec, 8'b1100_0000); end
    @(negedge refclk);
    @(negedge refclk);
    n_checks++;
    if (dut_vec !== 8'b1100_0000) begin n_fail++; $display("FAIL rst_async_held got %b want %b", dut_vec, 8'b1100_0000); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int len;
    rst = 1'b1; pll_locked = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
    for (int s = 0; s < 80; s++) begin
      pll_locked = ($urandom_range(0, 2) != 0);
      len = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 45);
      repeat (len) begin
        @(negedge refclk);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_model seg %0d got %b want %b", s, dut_vec, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock(4'd1);
    test_lock_loss(4'd1);
    test_glitch(6, 4'd1);
    test_lock_loss(4'd1);
    test_glitch(7, 4'd1);
    test_saturate(1);
    test_rst_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
